// File: rtl/alu_mul_seq.sv
// 8x8 unsigned shift-add multiplier that borrows the core ALU adder for eight cycles.
// The adder carry is rebuilt from operand/result MSBs since the ALU exports none.

module alu_mul_seq_carry (
  input  logic a_msb,
  input  logic b_msb,
  input  logic s_msb,
  output logic carry
);
  // Carry out of an 8-bit add: both MSBs set, or one set and the sum MSB cleared.
  assign carry = (a_msb & b_msb) | ((a_msb | b_msb) & ~s_msb);
endmodule

module alu_mul_seq (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       start_in,
  input  logic [7:0] a_in,
  input  logic [7:0] b_in,
  input  logic       seg_sel_in,
  output logic       busy_out,
  output logic       done_out,
  output logic [7:0] result_out,
  output logic       alu_own_out,
  output logic [2:0] alu_unit_sel_out,
  output logic       alu_op_sel_out,
  output logic [7:0] alu_acc_out,
  output logic [7:0] alu_src_out,
  input  logic [7:0] alu_res_in
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] mcand, hi, lo;
  logic [2:0] cnt;
  logic [7:0] addend;
  logic       carry;

  // Partial product term for this iteration: multiplicand gated by the current multiplier bit.
  assign addend = lo[0] ? mcand : 8'h00;

  alu_mul_seq_carry u_carry (
    .a_msb (hi[7]),
    .b_msb (addend[7]),
    .s_msb (alu_res_in[7]),
    .carry (carry)
  );

  assign alu_unit_sel_out = 3'b000;
  assign alu_op_sel_out   = 1'b0;
  assign result_out       = seg_sel_in ? hi : lo;

  always_comb begin
    state_nxt   = state;
    busy_out    = 1'b0;
    done_out    = 1'b0;
    alu_own_out = 1'b0;
    alu_acc_out = 8'h00;
    alu_src_out = 8'h00;
    case (state)
      S_IDLE: begin
        if (start_in) state_nxt = S_RUN;
      end
      S_RUN: begin
        busy_out    = 1'b1;
        alu_own_out = 1'b1;
        alu_acc_out = hi;
        alu_src_out = addend;
        if (cnt == 3'd7) state_nxt = S_DONE;
      end
      S_DONE: begin
        busy_out  = 1'b1;
        done_out  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= S_IDLE;
      mcand <= 8'h00;
      hi    <= 8'h00;
      lo    <= 8'h00;
      cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (start_in) begin
            mcand <= a_in;
            lo    <= b_in;
            hi    <= 8'h00;
            cnt   <= 3'd0;
          end
        end
        S_RUN: begin
          // Shift the 17-bit {carry,sum,lo} right by one; lo drains multiplier bits as product bits fill in.
          {hi, lo} <= {carry, alu_res_in, lo[7:1]};
          cnt      <= cnt + 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
